// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S / left-justified / TDM transmitter:
// mode encodings and frame-geometry helpers.
package i2s_pkg;

    localparam int I2S_MODE_I2S = 0;
    localparam int I2S_MODE_LJ  = 1;
    localparam int I2S_MODE_TDM = 2;

    function automatic int frame_bits(input int channels, input int slot_bits);
        return channels * slot_bits;
    endfunction

    // Bclk periods between the frame-clock edge and the frame MSB.
    function automatic int frame_delay(input int mode);
        return (mode == I2S_MODE_LJ) ? 0 : 1;
    endfunction

endpackage

// File: rtl/i2s_tdm_clkgen.sv
// Bit-clock divider, frame bit index and frame-clock generation; flags the
// falling bclk edges on which the serialiser shifts or loads a new frame.
module i2s_tdm_clkgen
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int FRAME   = 64,
    parameter int MODE    = I2S_MODE_I2S
) (
    input  logic clk,
    input  logic rst,
    output logic bclk_o,
    output logic bclk_falling_o,
    output logic lrclk_o,
    output logic shift_o,
    output logic load_o
);

    localparam int   DELAY  = frame_delay(MODE);
    localparam int   DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int   B_W    = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam logic LR_RST = (MODE == I2S_MODE_LJ);

    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    logic             fall_q, fall_d;
    logic [B_W-1:0]   b_q, b_d;
    logic             lrclk_q, lrclk_d;
    logic             tick;
    logic             falling_now;
    logic [B_W-1:0]   b_next;

    always_comb begin
        tick        = (div_q == DIV_W'(CLK_DIV - 1));
        falling_now = tick && bclk_q;
        b_next      = (b_q == B_W'(FRAME - 1)) ? '0 : b_q + B_W'(1);
        div_d       = tick ? '0 : div_q + DIV_W'(1);
        bclk_d      = tick ? ~bclk_q : bclk_q;
        fall_d      = falling_now;
        b_d         = b_q;
        lrclk_d     = lrclk_q;
        if (falling_now) begin
            b_d = b_next;
            case (MODE)
                I2S_MODE_I2S: lrclk_d = (b_next >= B_W'(FRAME / 2));
                I2S_MODE_LJ:  lrclk_d = (b_next < B_W'(FRAME / 2));
                default:      lrclk_d = (b_next == '0);
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            bclk_q  <= 1'b0;
            fall_q  <= 1'b0;
            b_q     <= B_W'(FRAME - 1);
            lrclk_q <= LR_RST;
        end else begin
            div_q   <= div_d;
            bclk_q  <= bclk_d;
            fall_q  <= fall_d;
            b_q     <= b_d;
            lrclk_q <= lrclk_d;
        end
    end

    assign bclk_o         = bclk_q;
    assign bclk_falling_o = fall_q;
    assign lrclk_o        = lrclk_q;
    assign shift_o        = falling_now;
    assign load_o         = falling_now && (b_next == B_W'(DELAY));

endmodule

// File: rtl/i2s_tdm_tx.sv
// Multi-format audio serial transmitter: one-deep frame holding buffer with a
// valid/ready input, frame shift register and underrun flag.
module i2s_tdm_tx
    import i2s_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int DATA_BITS = 24,
    parameter int SLOT_BITS = 32,
    parameter int CHANNELS  = 2,
    parameter int MODE      = I2S_MODE_I2S
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS*DATA_BITS-1:0] in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          bclk_falling,
    output logic                          sdata,
    output logic                          underrun
);

    localparam int FRAME = frame_bits(CHANNELS, SLOT_BITS);
    localparam int W     = CHANNELS * DATA_BITS;

    if (SLOT_BITS < DATA_BITS) begin : g_bad_slot
        $error("i2s_tdm_tx: SLOT_BITS must be >= DATA_BITS");
    end
    if (MODE != I2S_MODE_TDM && CHANNELS != 2) begin : g_bad_channels
        $error("i2s_tdm_tx: I2S and left-justified modes need CHANNELS == 2");
    end
    if (MODE < 0 || MODE > I2S_MODE_TDM || CHANNELS < 1 || CHANNELS > 16 || CLK_DIV < 1) begin : g_bad_param
        $error("i2s_tdm_tx: unsupported MODE, CHANNELS or CLK_DIV");
    end

    // Handshake: a word transfers on a rising clk edge where in_valid and
    // in_ready are both high; in_ready depends only on DUT state, never on in_valid.
    logic [W-1:0]     buf_q, buf_d;
    logic             full_q, full_d;
    logic [FRAME-1:0] shift_q, shift_d;
    logic             sdata_q, sdata_d;
    logic             underrun_q, underrun_d;
    logic [FRAME-1:0] load_frame;
    logic             load_now;
    logic             shift_now;
    logic             accept;

    i2s_tdm_clkgen #(
        .CLK_DIV (CLK_DIV),
        .FRAME   (FRAME),
        .MODE    (MODE)
    ) u_clkgen (
        .clk            (clk),
        .rst            (rst),
        .bclk_o         (bclk),
        .bclk_falling_o (bclk_falling),
        .lrclk_o        (lrclk),
        .shift_o        (shift_now),
        .load_o         (load_now)
    );

    // Slot 0 sits at the top of the frame so it is transmitted first.
    function automatic logic [FRAME-1:0] pack_frame(input logic [W-1:0] d);
        logic [FRAME-1:0] f;
        f = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            f[FRAME-1-k*SLOT_BITS -: DATA_BITS] = d[k*DATA_BITS +: DATA_BITS];
        end
        return f;
    endfunction

    assign in_ready = !full_q || load_now;
    assign accept   = in_valid && in_ready;

    always_comb begin
        buf_d      = buf_q;
        full_d     = full_q;
        shift_d    = shift_q;
        sdata_d    = sdata_q;
        underrun_d = 1'b0;
        load_frame = full_q ? pack_frame(buf_q) : '0;
        if (load_now) begin
            sdata_d    = load_frame[FRAME-1];
            shift_d    = load_frame << 1;
            full_d     = 1'b0;
            underrun_d = !full_q;
        end else if (shift_now) begin
            sdata_d = shift_q[FRAME-1];
            shift_d = shift_q << 1;
        end
        if (accept) begin
            buf_d  = in_data;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q      <= '0;
            full_q     <= 1'b0;
            shift_q    <= '0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            full_q     <= full_d;
            shift_q    <= shift_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
        end
    end

    assign sdata    = sdata_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Bench for i2s_tdm_tx: three configurations (I2S, left-justified, 8-slot TDM)
// checked every clk against a timing/buffer model derived from cycle arithmetic.
module tb_i2s_tdm_tx;

  logic clk;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  localparam int FIRST_T [3] = '{8, 2, 8};
  localparam int PERIOD_T [3] = '{256, 128, 512};
  localparam int SLOT1_T [3] = '{8'h3C, 8'h3C, 8'h11};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g, input int n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst=%0d n=%0d got=%0d expected=%0d", nm, g, n, act, exp);
    end
  endtask

  // Bit p of a frame in transmission order: slot p/sb, MSB first, zero padded.
  function automatic bit fbit(input logic [127:0] d, input int p, input int sb, input int db);
    int k;
    int i;
    k = p / sb;
    i = p % sb;
    if (i >= db) return 1'b0;
    return d[k*db + db - 1 - i];
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int MODE = g;
    localparam int CD = (g == 1) ? 1 : 2;
    localparam int CH = (g == 2) ? 8 : 2;
    localparam int DB = (g == 2) ? 16 : 24;
    localparam int SB = (g == 2) ? 16 : 32;
    localparam int W = CH * DB;
    localparam int FRAME = CH * SB;
    localparam int DELAY = (g == 1) ? 0 : 1;
    localparam int FRAME_CLK = 2 * CD * FRAME;
    localparam int FIRST_UR = FIRST_T[g];
    localparam bit LR_RST = (g == 1);

    logic         rst;
    logic [W-1:0] din;
    logic         vld;
    logic         rdy_o, bclk_o, lr_o, fall_o, sd_o, ur_o;

    i2s_tdm_tx #(
      .CLK_DIV   (CD),
      .DATA_BITS (DB),
      .SLOT_BITS (SB),
      .CHANNELS  (CH),
      .MODE      (MODE)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (din),
      .in_valid     (vld),
      .in_ready     (rdy_o),
      .bclk         (bclk_o),
      .lrclk        (lr_o),
      .bclk_falling (fall_o),
      .sdata        (sd_o),
      .underrun     (ur_o)
    );

    int           n, e, b, j, nn, len, ur_cnt, ur_n0, ur_n1, post_ur;
    bit           fall_x, lr_x, sd_x, ld, rdy_x, acc, full, exp_ur;
    bit           cur_dir, buf_dir, dir_pending, inc_pending, stop, did_reset;
    logic [W-1:0] bufd, cur, dirv;
    logic [7:0]   cap;

    initial begin : run
      rst = 1'b1; vld = 1'b0; din = '0;
      n = 0; full = 0; exp_ur = 0; cur = '0; bufd = '0;
      cur_dir = 0; buf_dir = 0; inc_pending = 0; did_reset = 0;
      ur_cnt = 0; ur_n0 = -1; ur_n1 = -1; post_ur = -1; cap = '0;
      for (int k = 0; k < CH; k++)
        dirv[k*DB +: DB] = (g == 2) ? DB'(16'h1111 * k) : ((k == 0) ? DB'(24'hA5A5A5) : DB'(24'h3C3C3C));
      repeat (3) @(negedge clk);
      rst = 1'b0;

      for (int ph = 0; ph < 6; ph++) begin
        len = (ph == 1 || ph == 3) ? 4 * FRAME_CLK : ((ph == 2) ? FRAME_CLK : 2 * FRAME_CLK);
        stop = 0;
        dir_pending = (ph == 1);
        for (int c = 0; c < len && !stop; c++) begin
          // expected outputs after rising edge n since reset release
          e = n / (2 * CD);
          fall_x = (n > 0) && (n % (2 * CD) == 0);
          b = (e - 1) % FRAME;
          if (e == 0) lr_x = LR_RST;
          else if (MODE == 0) lr_x = (b >= FRAME / 2);
          else if (MODE == 1) lr_x = (b < FRAME / 2);
          else lr_x = (b == 0);
          j = e - 1 - DELAY;
          sd_x = (e == 0 || j < 0) ? 1'b0 : fbit(128'(cur), j % FRAME, SB, DB);
          nn = n + 1;
          ld = (nn % (2 * CD) == 0) && (((nn / (2 * CD)) - 1) % FRAME == DELAY);
          rdy_x = !full || ld;
          chk("bclk", g, n, int'(bclk_o), (n / CD) % 2);
          chk("bclk_falling", g, n, int'(fall_o), int'(fall_x));
          chk("lrclk", g, n, int'(lr_o), int'(lr_x));
          chk("sdata", g, n, int'(sd_o), int'(sd_x));
          chk("underrun", g, n, int'(ur_o), int'(exp_ur));
          chk("in_ready", g, n, int'(rdy_o), int'(rdy_x));

          if (ur_o && ph == 0) begin
            if (ur_cnt == 0) ur_n0 = n;
            else if (ur_cnt == 1) ur_n1 = n;
            ur_cnt++;
          end
          if (ur_o && ph == 5 && post_ur < 0) post_ur = n;
          if (fall_x && cur_dir && j >= 0 && (j % FRAME) >= SB && (j % FRAME) < SB + 8)
            cap = {cap[6:0], sd_o};

          if (ph == 4 && fall_x && b == 20 && full) begin
            rst = 1'b1;
            vld = 1'b0;
            #1;
            chk("rst_bclk", g, n, int'(bclk_o), 0);
            chk("rst_lrclk", g, n, int'(lr_o), int'(LR_RST));
            chk("rst_sdata", g, n, int'(sd_o), 0);
            chk("rst_bclk_falling", g, n, int'(fall_o), 0);
            chk("rst_underrun", g, n, int'(ur_o), 0);
            chk("rst_in_ready", g, n, int'(rdy_o), 1);
            repeat (2) @(negedge clk);
            rst = 1'b0;
            n = 0; full = 0; cur = '0; exp_ur = 0; cur_dir = 0; buf_dir = 0;
            stop = 1; did_reset = 1;
          end else begin
            case (ph)
              0, 2: vld = 1'b0;
              1, 4: vld = 1'b1;
              3: vld = ($urandom_range(0, 3) != 0);
              default: vld = (c > FIRST_UR + 4) && ($urandom_range(0, 1) == 1);
            endcase
            if (ph == 1 && c == 0) din = dirv;
            else if (ph == 1 && inc_pending) begin
              din = din + 1'b1;
              inc_pending = 0;
            end else if (ph >= 3) din = W'({$urandom, $urandom, $urandom, $urandom});

            acc = vld && rdy_x;
            exp_ur = ld && !full;
            if (ld) begin
              cur = full ? bufd : '0;
              cur_dir = full && buf_dir;
            end
            if (acc) begin
              bufd = din;
              full = 1;
              buf_dir = (ph == 1) && dir_pending;
              dir_pending = 0;
              inc_pending = (ph == 1);
            end else if (ld) begin
              full = 0;
            end
            n++;
            @(negedge clk);
          end
        end
      end

      chk("first_underrun_cycle", g, 0, ur_n0, FIRST_UR);
      chk("underrun_period", g, 0, ur_n1 - ur_n0, PERIOD_T[g]);
      chk("slot1_msbs", g, 0, int'(cap), SLOT1_T[g]);
      chk("midframe_reset_reached", g, 0, int'(did_reset), 1);
      chk("post_reset_underrun_cycle", g, 0, post_ur, FIRST_UR);
      done_cnt++;
    end
  end

  initial begin : main
    logic [127:0] pin_d;
    pin_d = {80'd0, 24'h3C3C3C, 24'hA5A5A5};
    chk("model_bit0", 0, 0, int'(fbit(pin_d, 0, 32, 24)), 1);
    chk("model_bit1", 0, 0, int'(fbit(pin_d, 1, 32, 24)), 0);
    chk("model_bit23", 0, 0, int'(fbit(pin_d, 23, 32, 24)), 1);
    chk("model_bit32", 0, 0, int'(fbit(pin_d, 32, 32, 24)), 0);
    chk("model_bit34", 0, 0, int'(fbit(pin_d, 34, 32, 24)), 1);
    for (int t = 0; t < 40000 && done_cnt < 3; t++) @(posedge clk);
    if (done_cnt < 3) begin
      checks++;
      errors++;
      $display("FAIL timeout done=%0d expected=3", done_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
